spi_bridge: RTL

SPI slave to register-bus bridge for the PWM generator. It receives SPI mode-0 frames from an external host, oversamples them in the system clock domain, and turns each frame into a single-cycle `read` or `write` strobe on the register file bus. For reads, it returns the register byte on MISO within the same frame. It is the only master of the register file's `read`/`write`/`addr`/`data_write` inputs.

---
 rtl/spi_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_bridge.sv
// SPI mode-0 slave to register-bus bridge: 16-bit frames (command byte, data byte)
// oversampled in the clk domain and turned into single-cycle read/write strobes.
module spi_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic [7:0] data_write,
    input  logic [7:0] data_read,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d;
    logic [7:0] rx_shift;
    logic       is_wr_q, is_wr_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_write_q, data_write_d;
    logic       miso_q, miso_d;
    logic       read_q, read_d, write_q, write_d, frame_err_q, frame_err_d;
    logic       ld1_q, ld1_d, ld2_q, ld2_d;
    logic       frame_done;

    // Equal-depth synchronizers keep sclk, cs_n and mosi aligned at detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign rx_shift  = {rx_q[6:0], mosi_s};
    assign frame_done = (state_q == DATA) && sclk_rise && (cnt_q == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (cs_rise) state_d = IDLE;
                     else if (sclk_rise && cnt_q == 4'd7) state_d = DATA;
            DATA:    if (cs_rise) state_d = IDLE;
                     else if (frame_done) state_d = CMD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        miso_d       = miso_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        frame_err_d  = 1'b0;
        ld1_d        = 1'b0;
        ld2_d        = ld1_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        is_wr_d = rx_shift[7];
                        addr_d  = rx_shift[5:0];
                        read_d  = ~rx_shift[7];
                        ld1_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        write_d = is_wr_q;
                        if (is_wr_q) data_write_d = rx_shift;
                    end
                end
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            default: ;
        endcase
        // Register data arrives two cycles after the command byte completes.
        if (ld2_q) tx_d = is_wr_q ? '0 : data_read;
        // A completing 16th rise wins over a coincident cs_n rise.
        if (cs_rise) begin
            miso_d = 1'b0;
            cnt_d  = '0;
            if (!frame_done) begin
                frame_err_d = (cnt_q != 4'd0);
                read_d      = 1'b0;
                ld1_d       = 1'b0;
                addr_d      = addr_q;
                is_wr_d     = is_wr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            miso_q       <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            ld1_q        <= 1'b0;
            ld2_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            miso_q       <= miso_d;
            read_q       <= read_d;
            write_q      <= write_d;
            frame_err_q  <= frame_err_d;
            ld1_q        <= ld1_d;
            ld2_q        <= ld2_d;
        end
    end

    assign miso       = miso_q & ~cs_s;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign frame_err  = frame_err_q;

endmodule
